piso_serializer_v2: RTL and testbench

Parametrised parallel-in/serial-out serializer with a valid/ready input handshake, a one-word holding buffer for gap-free back-to-back frames, and selectable bit order. It sits between a byte-wide datapath producer and the transmitter line driver. It advances one bit per external `shift_en` tick, so a baud/bit-rate generator sets the line rate independently of `clk`.

---
 rtl/piso_serializer_v2.sv | 166 ++++++++++++++++
 tb/tb_piso_serializer_v2.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer_v2.sv
// piso_serializer_v2: parallel-in/serial-out serializer with a valid/ready
// input handshake, a one-word holding buffer for gap-free back-to-back
// frames and selectable bit order. The line advances one bit per shift_en
// tick, so an external bit-rate generator sets the line rate.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN appends one even-parity
// bit after the data bits of every frame.
module piso_serializer_v2 #(
    parameter int   DATA_WIDTH = 8,
    parameter int   MSB_FIRST  = 0,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  shift_en,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic                  sof,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

`ifdef PISO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_DATA} state_t;
`endif

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] sreg, sreg_nxt;
    logic [DATA_WIDTH-1:0] hold, hold_nxt;
    logic                  hold_full, hold_full_nxt;
    logic                  ser_out_nxt, ser_valid_nxt, sof_nxt;
    logic                  accept, xfer, frame_end;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic                  par, par_nxt;
`endif

    // Bit that goes on the line first for a given shifter image.
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    // Shifter image after the presented bit has been consumed.
    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    assign accept = in_valid && in_ready;
    assign busy   = (state != ST_IDLE) || hold_full;

    // Next-state, shifter, holding-buffer and line decisions.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        sreg_nxt      = sreg;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        ser_out_nxt   = ser_out;
        ser_valid_nxt = ser_valid;
        sof_nxt       = sof;
`ifdef PISO_SERIALIZER_PARITY_EN
        par_nxt       = par;
`endif
        frame_end     = 1'b0;
        xfer          = 1'b0;

        case (state)
            ST_IDLE: begin
                // Ticks while idle carry no data and are dropped.
            end
            ST_DATA: begin
                if (shift_en) begin
                    if (cnt != LAST_BIT) begin
                        cnt_nxt     = cnt + CNT_W'(1);
                        sreg_nxt    = advance(sreg);
                        ser_out_nxt = first_bit(advance(sreg));
                        sof_nxt     = 1'b0;
                    end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
                        state_nxt   = ST_PARITY;
                        ser_out_nxt = par;
                        sof_nxt     = 1'b0;
`else
                        frame_end   = 1'b1;
`endif
                    end
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (shift_en) begin
                    frame_end = 1'b1;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase

        // Frame over with nothing queued: park the line at its idle level.
        if (frame_end) begin
            state_nxt     = ST_IDLE;
            ser_out_nxt   = IDLE_LEVEL;
            ser_valid_nxt = 1'b0;
            sof_nxt       = 1'b0;
        end

        // Load the shifter from hold, either from idle or seamlessly on the
        // tick that ends the previous frame.
        xfer = hold_full && ((state == ST_IDLE) || frame_end);
        if (xfer) begin
            state_nxt     = ST_DATA;
            cnt_nxt       = '0;
            sreg_nxt      = hold;
            ser_out_nxt   = first_bit(hold);
            ser_valid_nxt = 1'b1;
            sof_nxt       = 1'b1;
            hold_full_nxt = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_nxt       = ^hold;
`endif
        end

        // A new word may refill hold in the same cycle it is emptied.
        if (accept) begin
            hold_nxt      = in_data;
            hold_full_nxt = 1'b1;
        end
    end

    // Control state and line outputs; these are the only reset registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hold_full <= 1'b0;
            in_ready  <= 1'b0;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            sof       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hold_full <= hold_full_nxt;
            in_ready  <= !hold_full_nxt;
            ser_out   <= ser_out_nxt;
            ser_valid <= ser_valid_nxt;
            sof       <= sof_nxt;
        end
    end

    // Data registers; their contents only matter once qualified by control.
    always_ff @(posedge clk) begin
        sreg <= sreg_nxt;
        hold <= hold_nxt;
`ifdef PISO_SERIALIZER_PARITY_EN
        par  <= par_nxt;
`endif
    end

endmodule

// File: tb/tb_piso_serializer_v2.sv
// tb_piso_serializer_v2: directed bench for piso_serializer_v2 with a
// bit-queue model of the expected line stream (one LSB-first and one
// MSB-first instance).
`timescale 1ns/1ps
module tb_piso_serializer_v2;

    localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iv0 = 1'b0, se0 = 1'b0, ir0, so0, sv0, sof0, bz0;
    logic       iv1 = 1'b0, se1 = 1'b0, ir1, so1, sv1, sof1, bz1;
    logic [7:0] id0 = 8'h00, id1 = 8'h00;

    int checks = 0;
    int failures = 0;
    int per0 = 0, per1 = 0, tc0 = 0, tc1 = 0;

    // Expected stream entries: {sof, bit}
    logic [1:0] exp0[$];
    logic [1:0] exp1[$];
    logic [31:0] cap0 = '0, capsof0 = '0, cap1 = '0;
    int capn0 = 0, capn1 = 0;
    int gap0 = 0, gap_limit = 0;

    piso_serializer_v2 #(.DATA_WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_data(id0), .in_ready(ir0),
        .shift_en(se0), .ser_out(so0), .ser_valid(sv0), .sof(sof0), .busy(bz0)
    );

    piso_serializer_v2 #(.DATA_WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
        .shift_en(se1), .ser_out(so1), .ser_valid(sv1), .sof(sof1), .busy(bz1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // A word accepted by the DUT must later appear on the line as these bits.
    task automatic push_word(input int inst, input logic [7:0] w);
        logic [1:0] e;
        for (int i = 0; i < W; i++) begin
            e = {(i == 0), (inst == 1) ? w[W-1-i] : w[i]};
            if (inst == 0) exp0.push_back(e); else exp1.push_back(e);
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        e = {1'b0, ^w};
        if (inst == 0) exp0.push_back(e); else exp1.push_back(e);
`endif
    endtask

    task automatic mon(input int inst);
        logic so, sf, sv, se, iv, ir;
        logic [7:0] id;
        logic [1:0] e;
        int qn;
        if (inst == 0) begin
            so = so0; sf = sof0; sv = sv0; se = se0; iv = iv0; ir = ir0; id = id0; qn = exp0.size();
        end else begin
            so = so1; sf = sof1; sv = sv1; se = se1; iv = iv1; ir = ir1; id = id1; qn = exp1.size();
        end
        if (rst) begin
            if (inst == 0) exp0.delete(); else exp1.delete();
            return;
        end
        if (iv && ir) push_word(inst, id);
        if (inst == 0 && !sv && capn0 > 0 && capn0 < gap_limit) gap0++;
        if (sv) begin
            if (se) begin
                if (qn == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bit inst%0d: got bit %0b expected no frame bit", inst, so);
                end else begin
                    if (inst == 0) e = exp0.pop_front(); else e = exp1.pop_front();
                    chk($sformatf("ser_out inst%0d", inst), {31'b0, so}, {31'b0, e[0]});
                    chk($sformatf("sof inst%0d", inst), {31'b0, sf}, {31'b0, e[1]});
                    if (inst == 0) begin
                        cap0 = {cap0[30:0], so};
                        capsof0 = {capsof0[30:0], sf};
                        capn0++;
                    end else begin
                        cap1 = {cap1[30:0], so};
                        capn1++;
                    end
                end
            end
        end else begin
            chk($sformatf("idle_level inst%0d", inst), {31'b0, so}, 32'd1);
            chk($sformatf("idle_sof inst%0d", inst), {31'b0, sf}, 32'd0);
        end
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Bit-rate tick generators.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (per0 == 0) begin se0 = 1'b0; tc0 = 0; end
            else begin tc0 = (tc0 + 1) % per0; se0 = (tc0 == 0); end
            if (per1 == 0) begin se1 = 1'b0; tc1 = 0; end
            else begin tc1 = (tc1 + 1) % per1; se1 = (tc1 == 0); end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a word on the input until it is accepted; reports how many cycles
    // it was held off and the sof level seen when in_ready rose.
    task automatic offer(input int inst, input logic [7:0] w, output int waited, output logic sof_at_ready);
        if (inst == 0) begin iv0 = 1'b1; id0 = w; end else begin iv1 = 1'b1; id1 = w; end
        waited = 0;
        while (!((inst == 0) ? ir0 : ir1) && waited < 300) begin
            cyc(1);
            waited++;
        end
        sof_at_ready = (inst == 0) ? sof0 : sof1;
        if (!((inst == 0) ? ir0 : ir1)) begin
            checks++;
            failures++;
            $display("FAIL offer_timeout inst%0d: got in_ready 0 expected 1", inst);
        end
        cyc(1);
        if (inst == 0) begin iv0 = 1'b0; id0 = 8'h5A; end else begin iv1 = 1'b0; id1 = 8'h5A; end
    endtask

    task automatic wait_idle(input int inst);
        int n = 0;
        while (((inst == 0) ? (bz0 || sv0) : (bz1 || sv1)) && n < 1000) begin
            cyc(1);
            n++;
        end
        if ((inst == 0) ? (bz0 || sv0) : (bz1 || sv1)) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout inst%0d: got busy 1 expected 0", inst);
        end
    endtask

    task automatic wait_bits(input int nbits);
        int n = 0;
        while (capn0 < nbits && n < 1000) begin
            cyc(1);
            n++;
        end
        if (capn0 < nbits) begin
            checks++;
            failures++;
            $display("FAIL bits_timeout: got %0d bits expected %0d", capn0, nbits);
        end
    endtask

    initial begin
        int   w;
        logic sr;

        // Reset values
        rst = 1'b1;
        cyc(3);
        chk("rst_in_ready", {31'b0, ir0}, 32'd0);
        chk("rst_ser_valid", {31'b0, sv0}, 32'd0);
        chk("rst_ser_out", {31'b0, so0}, 32'd1);
        chk("rst_sof", {31'b0, sof0}, 32'd0);
        chk("rst_busy", {31'b0, bz0}, 32'd0);
        rst = 1'b0;
        cyc(1);
        chk("ready_after_rst", {31'b0, ir0}, 32'd1);

        // LSB-first 8'hA5, one tick every 4 cycles
        per0 = 4;
        capn0 = 0;
        offer(0, 8'hA5, w, sr);
        chk("hold_busy", {31'b0, bz0}, 32'd1);
        chk("hold_not_ready", {31'b0, ir0}, 32'd0);
        chk("latency_pre", {31'b0, sv0}, 32'd0);
        cyc(1);
        chk("first_valid", {31'b0, sv0}, 32'd1);
        chk("first_sof", {31'b0, sof0}, 32'd1);
        chk("first_bit", {31'b0, so0}, 32'd1);
        wait_idle(0);
        chk("a5_count", capn0, FL);
        chk("a5_bits", {24'b0, cap0[FL-1 -: 8]}, 32'b1010_0101);
        chk("a5_sof", capsof0 & ((32'd1 << FL) - 1), 32'd1 << (FL - 1));
        chk("a5_idle_out", {31'b0, so0}, 32'd1);

        // MSB-first 8'h81
        per1 = 3;
        capn1 = 0;
        offer(1, 8'h81, w, sr);
        wait_idle(1);
        chk("81_count", capn1, FL);
        chk("81_bits", {24'b0, cap1[FL-1 -: 8]}, 32'b1000_0001);

        // Back-to-back 8'h0F, 8'hF0
        per0 = 2;
        capn0 = 0;
        gap0 = 0;
        gap_limit = 2 * FL;
        offer(0, 8'h0F, w, sr);
        offer(0, 8'hF0, w, sr);
        chk("b2b_hold_not_ready", {31'b0, ir0}, 32'd0);
        chk("b2b_shifting", {31'b0, sv0}, 32'd1);
        wait_idle(0);
        gap_limit = 0;
        chk("b2b_count", capn0, 2 * FL);
        chk("b2b_gaps", gap0, 0);
        chk("b2b_sof", capsof0 & ((32'd1 << (2 * FL)) - 1), (32'd1 << (2 * FL - 1)) | (32'd1 << (FL - 1)));
        chk("b2b_word0", {24'b0, cap0[2*FL-1 -: 8]}, 32'b1111_0000);
        chk("b2b_word1", {24'b0, cap0[FL-1 -: 8]}, 32'b0000_1111);

        // Third word held off until the transfer frees hold
        per0 = 3;
        capn0 = 0;
        offer(0, 8'h11, w, sr);
        offer(0, 8'h22, w, sr);
        offer(0, 8'h33, w, sr);
        chk("third_held_off", {31'b0, (w > 0)}, 32'd1);
        chk("third_ready_at_xfer", {31'b0, sr}, 32'd1);
        wait_idle(0);
        chk("three_count", capn0, 3 * FL);
        chk("three_word0", {24'b0, cap0[3*FL-1 -: 8]}, 32'b1000_1000);
        chk("three_drained", exp0.size(), 0);

        // Reset mid-frame with hold full
        per0 = 2;
        capn0 = 0;
        offer(0, 8'h3C, w, sr);
        offer(0, 8'hFF, w, sr);
        wait_bits(3);
        chk("pre_rst_hold_full", {31'b0, ir0}, 32'd0);
        rst = 1'b1;
        cyc(1);
        chk("midrst_ser_valid", {31'b0, sv0}, 32'd0);
        chk("midrst_ser_out", {31'b0, so0}, 32'd1);
        chk("midrst_busy", {31'b0, bz0}, 32'd0);
        chk("midrst_sof", {31'b0, sof0}, 32'd0);
        chk("midrst_in_ready", {31'b0, ir0}, 32'd0);
        rst = 1'b0;
        cyc(1);
        chk("post_rst_ready", {31'b0, ir0}, 32'd1);
        capn0 = 0;
        offer(0, 8'h01, w, sr);
        wait_idle(0);
        chk("post_rst_count", capn0, FL);
        chk("post_rst_bits", {24'b0, cap0[FL-1 -: 8]}, 32'b1000_0000);

`ifdef PISO_SERIALIZER_PARITY_EN
        // Parity bit follows the data bits
        capn0 = 0;
        offer(0, 8'h07, w, sr);
        wait_idle(0);
        chk("par_07", {31'b0, cap0[0]}, 32'd1);
        capn0 = 0;
        offer(0, 8'h03, w, sr);
        wait_idle(0);
        chk("par_03", {31'b0, cap0[0]}, 32'd0);
`endif

        cyc(5);
        chk("end_drained0", exp0.size(), 0);
        chk("end_drained1", exp1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
